// File: rtl/player_pkg.sv
// Player executor shared types: opcodes, move directions, FSM states,
// instruction field helpers and the box clamp used by the mover.
package player_pkg;

  typedef enum logic [1:0] {
    ALIVE,
    INVULN,
    DEAD
  } state_e;

  localparam logic [3:0] OP_HPY = 4'd1;
  localparam logic [3:0] OP_DPY = 4'd2;
  localparam logic [3:0] OP_IDG = 4'd3;
  localparam logic [3:0] OP_SDG = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_SHP = 4'd6;

  localparam logic [7:0] DIR_UP    = 8'd0;
  localparam logic [7:0] DIR_LEFT  = 8'd1;
  localparam logic [7:0] DIR_DOWN  = 8'd2;
  localparam logic [7:0] DIR_RIGHT = 8'd3;

  function automatic logic [3:0] op_of(
    input logic [15:0] i
  );
    return i[15:12];
  endfunction

  function automatic logic [7:0] arg_of(
    input logic [15:0] i
  );
    return i[11:4];
  endfunction

  function automatic logic [9:0] clamp10(
    input logic signed [10:0] v,
    input logic signed [10:0] lo,
    input logic signed [10:0] hi
  );
    if (v < lo) return lo[9:0];
    if (v > hi) return hi[9:0];
    return v[9:0];
  endfunction

endpackage

// File: rtl/player_mover.sv
// Soul position: movement prescaler, direction decode and clamping
// to the dodge box. Recentre restarts the prescaler.
module player_mover
  import player_pkg::*;
#(
  parameter int MOVE_DIV = 250_000,
  parameter int STEP     = 2,
  parameter int BOX_X0   = 220,
  parameter int BOX_X1   = 420,
  parameter int BOX_Y0   = 240,
  parameter int BOX_Y1   = 400,
  parameter int SOUL_SZ  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       move_en_i,
  input  logic       recentre_i,
  input  logic [7:0] dir_i,
  output logic [9:0] posX_o,
  output logic [9:0] posY_o
);

  localparam int PW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(MOVE_DIV - 1);

  localparam logic signed [10:0] ST  = 11'(STEP);
  localparam logic signed [10:0] XLO = 11'(BOX_X0);
  localparam logic signed [10:0] XHI = 11'(BOX_X1 - SOUL_SZ);
  localparam logic signed [10:0] YLO = 11'(BOX_Y0);
  localparam logic signed [10:0] YHI = 11'(BOX_Y1 - SOUL_SZ);
  localparam logic [9:0] CX = 10'((BOX_X0 + BOX_X1 - SOUL_SZ) / 2);
  localparam logic [9:0] CY = 10'((BOX_Y0 + BOX_Y1 - SOUL_SZ) / 2);

  logic [PW-1:0] ps_q, ps_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic signed [10:0] nx, ny;
  logic wrap;

  always_comb begin
    ps_d = ps_q;
    x_d  = x_q;
    y_d  = y_q;
    nx   = $signed({1'b0, x_q});
    ny   = $signed({1'b0, y_q});
    wrap = (ps_q == PS_LAST);
    if (recentre_i) begin
      ps_d = '0;
      x_d  = CX;
      y_d  = CY;
    end else if (run_i) begin
      ps_d = wrap ? '0 : ps_q + 1'b1;
      if (wrap && move_en_i) begin
        unique case (1'b1)
          (dir_i == DIR_UP):    ny = ny - ST;
          (dir_i == DIR_LEFT):  nx = nx - ST;
          (dir_i == DIR_DOWN):  ny = ny + ST;
          (dir_i == DIR_RIGHT): nx = nx + ST;
          default: ;
        endcase
        x_d = clamp10(nx, XLO, XHI);
        y_d = clamp10(ny, YLO, YHI);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_q <= '0;
      x_q  <= CX;
      y_q  <= CY;
    end else begin
      ps_q <= ps_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign posX_o = x_q;
  assign posY_o = y_q;

endmodule

// File: rtl/player_executor.sv
// Executes FSM player instructions: HP, hit invulnerability, death,
// and soul movement through player_mover.
module player_executor
  import player_pkg::*;
#(
  parameter int HP_MAX     = 100,
  parameter int INV_CYCLES = 50_000_000,
  parameter int MOVE_DIV   = 250_000,
  parameter int STEP       = 2,
  parameter int BOX_X0     = 220,
  parameter int BOX_X1     = 420,
  parameter int BOX_Y0     = 240,
  parameter int BOX_Y1     = 400,
  parameter int SOUL_SZ    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        isMove,
  input  logic        startDmg,
  output logic [7:0]  hp,
  output logic [9:0]  posX,
  output logic [9:0]  posY,
  output logic        isDeath,
  output logic        invuln,
  output logic        dmgAck
);

  localparam int TW = $clog2(INV_CYCLES + 1);
  localparam logic [TW-1:0] TLOAD = TW'(INV_CYCLES - 1);
  localparam logic [7:0] HPM = 8'(HP_MAX);

  state_e st_q, st_d;
  logic [7:0] hp_q, hp_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic ack_q;
  logic [3:0] op;
  logic [7:0] arg;
  logic [8:0] sum;
  logic is_shp, hit, heal;
  logic unused_pad;

  assign op  = op_of(instr);
  assign arg = arg_of(instr);
  assign unused_pad = ^instr[3:0];

  assign is_shp = (op == OP_SHP);
  assign hit    = startDmg && (op == OP_DPY) && (arg != 8'd0);
  assign heal   = startDmg && (op == OP_HPY);
  assign sum    = {1'b0, hp_q} + {1'b0, arg};

  always_comb begin
    st_d  = st_q;
    hp_d  = hp_q;
    tmr_d = tmr_q;
    if (is_shp) begin
      hp_d  = (arg > HPM) ? HPM : arg;
      tmr_d = '0;
      st_d  = (arg != 8'd0) ? ALIVE : DEAD;
    end else begin
      unique case (st_q)
        ALIVE: begin
          if (hit) begin
            if (hp_q <= arg) begin
              hp_d = 8'd0;
              st_d = DEAD;
            end else begin
              hp_d  = hp_q - arg;
              st_d  = INVULN;
              tmr_d = TLOAD;
            end
          end
        end
        INVULN: begin
          if (tmr_q == '0) st_d = ALIVE;
          else tmr_d = tmr_q - 1'b1;
        end
        default: ;
      endcase
      // Heal never coincides with a hit: they are distinct opcodes.
      if (heal && st_q != DEAD) begin
        hp_d = (sum > {1'b0, HPM}) ? HPM : sum[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= ALIVE;
      hp_q  <= HPM;
      tmr_q <= '0;
      ack_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      hp_q  <= hp_d;
      tmr_q <= tmr_d;
      ack_q <= startDmg;
    end
  end

  player_mover #(
    .MOVE_DIV (MOVE_DIV),
    .STEP     (STEP),
    .BOX_X0   (BOX_X0),
    .BOX_X1   (BOX_X1),
    .BOX_Y0   (BOX_Y0),
    .BOX_Y1   (BOX_Y1),
    .SOUL_SZ  (SOUL_SZ)
  ) u_mover (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (st_q != DEAD),
    .move_en_i  (isMove && (op == OP_MOV)),
    .recentre_i (is_shp),
    .dir_i      (arg),
    .posX_o     (posX),
    .posY_o     (posY)
  );

  assign hp      = hp_q;
  assign isDeath = (st_q == DEAD);
  assign invuln  = (st_q == INVULN);
  assign dmgAck  = ack_q;

endmodule

// File: tb/tb_player_executor.sv
// Directed bench for player_executor: opcode vector table plus
// sequences for invulnerability, death, saturation, movement, reset.
module tb_player_executor;
  import player_pkg::*;

  localparam int CX = (220 + 420 - 16) / 2;
  localparam int CY = (240 + 400 - 16) / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] instr = 16'h0;
  logic isMove = 1'b0;
  logic startDmg = 1'b0;

  logic [7:0] hp, hp2;
  logic [9:0] posX, posY, posX2, posY2;
  logic isDeath, invuln, dmgAck;
  logic isDeath2, invuln2, dmgAck2;

  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  player_executor #(
    .MOVE_DIV(4), .INV_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .isMove(isMove), .startDmg(startDmg),
    .hp(hp), .posX(posX), .posY(posY),
    .isDeath(isDeath), .invuln(invuln), .dmgAck(dmgAck)
  );

  player_executor #(
    .HP_MAX(255), .MOVE_DIV(4), .INV_CYCLES(8)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .isMove(isMove), .startDmg(startDmg),
    .hp(hp2), .posX(posX2), .posY(posY2),
    .isDeath(isDeath2), .invuln(invuln2), .dmgAck(dmgAck2)
  );

  typedef struct {
    logic [15:0] ins;
    logic        s;
    logic [7:0]  hp;
    logic        d;
    logic        inv;
    logic        ack;
  } vec_t;

  vec_t tv [14];

  function automatic logic [15:0] mk(
    input logic [3:0] op,
    input logic [7:0] arg
  );
    return {op, arg, 4'h0};
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic move_run(
    input logic [7:0] dir,
    input int ncyc,
    input int ex,
    input int ey,
    input string nm
  );
    int px, py, last, nchg, bad, dlt;
    px = posX; py = posY;
    last = 0; nchg = 0; bad = 0;
    instr = mk(OP_MOV, dir);
    isMove = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (int'(posX) != px || int'(posY) != py) begin
        dlt = (int'(posX) > px ? int'(posX) - px : px - int'(posX))
            + (int'(posY) > py ? int'(posY) - py : py - int'(posY));
        if (dlt != 2) bad++;
        if (nchg > 0 && i - last != 4) bad++;
        nchg++;
        last = i;
        px = posX; py = posY;
      end
    end
    isMove = 1'b0;
    chk({nm, "_step"}, bad, 0);
    chk({nm, "_x"}, posX, ex);
    chk({nm, "_y"}, posY, ey);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    tv[0]  = '{mk(OP_SHP, 8'd100), 1'b0, 8'd100, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{mk(OP_HPY, 8'd5),   1'b1, 8'd100, 1'b0, 1'b0, 1'b1};
    tv[2]  = '{mk(OP_DPY, 8'd0),   1'b1, 8'd100, 1'b0, 1'b0, 1'b1};
    tv[3]  = '{mk(OP_DPY, 8'd30),  1'b1, 8'd70,  1'b0, 1'b1, 1'b1};
    tv[4]  = '{mk(4'd0, 8'd0),     1'b0, 8'd70,  1'b0, 1'b1, 1'b0};
    tv[5]  = '{mk(OP_HPY, 8'd10),  1'b1, 8'd80,  1'b0, 1'b1, 1'b1};
    tv[6]  = '{mk(OP_DPY, 8'd40),  1'b1, 8'd80,  1'b0, 1'b1, 1'b1};
    tv[7]  = '{mk(OP_MOV, 8'd0),   1'b1, 8'd80,  1'b0, 1'b1, 1'b1};
    tv[8]  = '{mk(OP_SHP, 8'd20),  1'b0, 8'd20,  1'b0, 1'b0, 1'b0};
    tv[9]  = '{mk(OP_DPY, 8'd50),  1'b1, 8'd0,   1'b1, 1'b0, 1'b1};
    tv[10] = '{mk(OP_DPY, 8'd5),   1'b1, 8'd0,   1'b1, 1'b0, 1'b1};
    tv[11] = '{mk(OP_SHP, 8'd0),   1'b0, 8'd0,   1'b1, 1'b0, 1'b0};
    tv[12] = '{mk(OP_SHP, 8'd200), 1'b1, 8'd100, 1'b0, 1'b0, 1'b1};
    tv[13] = '{mk(OP_IDG, 8'd0),   1'b1, 8'd100, 1'b0, 1'b0, 1'b1};

    // reset and hold SHP 100
    rst_n = 1'b0;
    instr = mk(OP_SHP, 8'd100);
    tick();
    tick();
    chk("rst_hp", hp, 100);
    chk("rst_x", posX, CX);
    chk("rst_y", posY, CY);
    chk("rst_death", isDeath, 0);
    chk("rst_inv", invuln, 0);
    chk("rst_ack", dmgAck, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("hold_hp", hp, 100);
    chk("hold_x", posX, CX);
    chk("hold_y", posY, CY);
    chk("hold_death", isDeath, 0);

    // opcode vector table
    for (int i = 0; i < 14; i++) begin
      instr = tv[i].ins;
      startDmg = tv[i].s;
      tick();
      startDmg = 1'b0;
      chk($sformatf("v%0d_hp", i), hp, tv[i].hp);
      chk($sformatf("v%0d_death", i), isDeath, tv[i].d);
      chk($sformatf("v%0d_inv", i), invuln, tv[i].inv);
      chk($sformatf("v%0d_ack", i), dmgAck, tv[i].ack);
    end

    // invulnerability window and ignored second hit
    instr = mk(OP_SHP, 8'd100);
    tick();
    instr = mk(OP_DPY, 8'd30);
    startDmg = 1'b1;
    tick();
    startDmg = 1'b0;
    chk("hit_hp", hp, 70);
    chk("hit_inv", invuln, 1);
    chk("hit_ack", dmgAck, 1);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      if (k == 2) startDmg = 1'b1;
      tick();
      startDmg = 1'b0;
      if (k == 0) chk("hit_ack_drop", dmgAck, 0);
      if (invuln) cnt++;
      else break;
    end
    chk("inv_cycles", cnt, 8);
    chk("inv_hp", hp, 70);

    // death freezes movement, SHP revives
    instr = mk(OP_SHP, 8'd20);
    tick();
    instr = mk(OP_DPY, 8'd50);
    startDmg = 1'b1;
    tick();
    startDmg = 1'b0;
    chk("die_hp", hp, 0);
    chk("die_death", isDeath, 1);
    instr = mk(OP_MOV, DIR_LEFT);
    isMove = 1'b1;
    repeat (20) tick();
    isMove = 1'b0;
    chk("dead_x", posX, CX);
    chk("dead_y", posY, CY);
    chk("dead_death", isDeath, 1);
    instr = mk(OP_SHP, 8'd100);
    tick();
    chk("revive_hp", hp, 100);
    chk("revive_death", isDeath, 0);
    chk("revive_x", posX, CX);

    // heal saturation at 100 and at 255
    instr = mk(OP_SHP, 8'd95);
    tick();
    instr = mk(OP_HPY, 8'd10);
    startDmg = 1'b1;
    tick();
    startDmg = 1'b0;
    chk("heal95_hp", hp, 100);
    chk("heal95_hp2", hp2, 105);
    instr = mk(OP_SHP, 8'd250);
    tick();
    chk("shp250_hp", hp, 100);
    chk("shp250_hp2", hp2, 250);
    instr = mk(OP_HPY, 8'd10);
    startDmg = 1'b1;
    tick();
    chk("heal250_hp2", hp2, 255);
    tick();
    startDmg = 1'b0;
    chk("heal255_hp2", hp2, 255);
    chk("heal255_hp", hp, 100);

    // movement and clamping
    instr = mk(OP_SHP, 8'd100);
    tick();
    move_run(DIR_LEFT, 250, 220, CY, "left");
    move_run(DIR_RIGHT, 450, 404, CY, "right");
    move_run(DIR_UP, 200, 404, 240, "up");
    move_run(DIR_DOWN, 400, 404, 384, "down");

    // reset in the middle of invulnerability
    instr = mk(OP_SHP, 8'd100);
    tick();
    instr = mk(OP_DPY, 8'd30);
    startDmg = 1'b1;
    tick();
    startDmg = 1'b0;
    instr = mk(OP_MOV, DIR_UP);
    isMove = 1'b1;
    repeat (6) tick();
    isMove = 1'b0;
    instr = mk(4'd0, 8'd0);
    chk("mid_inv", invuln, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_hp", hp, 100);
    chk("rst2_inv", invuln, 0);
    chk("rst2_death", isDeath, 0);
    chk("rst2_ack", dmgAck, 0);
    chk("rst2_x", posX, CX);
    chk("rst2_y", posY, CY);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
